// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave receiver: pin synchronisers, MSB-first word assembly, valid/ready output,
// MISO loopback of the last accepted word, sticky overrun / framing error flags.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              frame_err,
    input  logic              clr_err
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int SET_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {RESYNC, IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [SET_W-1:0]       settle_q, settle_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;
    logic settled, word_done, ov_evt, fr_evt;
    logic [DATA_W-1:0] word;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign settled  = (settle_q == SET_W'(SYNC_STAGES));
    assign word     = {shift_q[DATA_W-2:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        settle_d    = settled ? settle_q : settle_q + SET_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        word_done   = 1'b0;
        ov_evt      = 1'b0;
        fr_evt      = 1'b0;

        case (state_q)
            // Wait until the synchronisers hold real pin values and CS is idle, so a
            // frame already running when reset released is never half-captured.
            RESYNC: if (settled && (cs_s || !ena)) state_d = IDLE;
            IDLE: begin
                if (cs_fall && ena) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    tx_shift_d = rx_data_q;
                end
            end
            SHIFT: begin
                if (cs_rise || !ena) begin
                    state_d = IDLE;
                    fr_evt  = (bit_cnt_q != '0);
                end else begin
                    if (sck_rise) begin
                        shift_d = word;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_d = '0;
                            word_done = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    // bit_cnt==0 on a falling edge only happens right after a word wrapped
                    if (sck_fall)
                        tx_shift_d = (bit_cnt_q == '0) ? rx_data_q
                                                       : {tx_shift_q[DATA_W-2:0], 1'b0};
                end
            end
            default: state_d = RESYNC;
        endcase

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (word_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = word;
                rx_valid_d = 1'b1;
            end else begin
                ov_evt = 1'b1;
            end
        end

        overrun_d   = (overrun_q & ~clr_err) | ov_evt;
        frame_err_d = (frame_err_q & ~clr_err) | fr_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESYNC;
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            settle_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            settle_q    <= settle_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi_miso    = tx_shift_q[DATA_W-1];
    assign spi_miso_oe = (state_q == SHIFT);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign overrun     = overrun_q;
    assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed + randomized bench for spi_byte_rx acting as an SPI master at SCK = clk/8,
// checked against a word-level model of the receive/handshake/loopback rules.
module tb_spi_byte_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid, overrun, frame_err;
    logic       rx_ready = 1'b0, clr_err = 1'b0;

    int total = 0, bad = 0;

    // model state
    logic [7:0] m_data = 8'h00, m_last = 8'h00;
    logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
    logic [7:0] exp_q[$], acc_q[$];

    spi_byte_rx #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && rx_valid && rx_ready) acc_q.push_back(rx_data);

    initial begin
        #5ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input logic v);
        rx_ready = v;
        if (v && m_valid) begin exp_q.push_back(m_data); m_valid = 1'b0; end
        tick(2);
    endtask

    // Shift the top n bits of w; optionally pulse rx_ready exactly in the cycle the
    // final rising edge is acted on (pin edge + two sync flops + one register stage).
    task automatic send_bits(input logic [7:0] w, input int n, input bit pulse,
                             output logic [7:0] m);
        m = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = w[i];
            tick(4);
            m[i] = spi_miso;
            spi_sck = 1'b1;
            if (pulse && i == 0) begin
                tick(2); rx_ready = 1'b1; tick(1); rx_ready = 1'b0; tick(1);
            end else begin
                tick(4);
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] w, input bit pulse);
        logic [7:0] m, e;
        logic rdy_at, rdy_after;
        e = m_last;
        rdy_at = pulse ? 1'b1 : rx_ready;
        rdy_after = pulse ? 1'b0 : rx_ready;
        send_bits(w, 8, pulse, m);
        chk("miso_word", m, e);
        if (m_valid && rdy_at) begin exp_q.push_back(m_data); m_valid = 1'b0; end
        if (!m_valid) begin
            m_data = w; m_valid = 1'b1; m_last = w;
            if (rdy_after) begin exp_q.push_back(w); m_valid = 1'b0; end
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic cs_low;  spi_cs_n = 1'b0; tick(4); endtask
    task automatic cs_high; tick(4); spi_cs_n = 1'b1; tick(6); endtask

    task automatic check_out(input string tag);
        chk({tag, "_valid"}, rx_valid, m_valid);
        chk({tag, "_data"}, rx_data, m_data);
        chk({tag, "_ovr"}, overrun, m_ovr);
        chk({tag, "_ferr"}, frame_err, m_ferr);
    endtask

    task automatic clear_flags;
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
        m_ovr = 1'b0; m_ferr = 1'b0;
        chk("clr_ovr", overrun, 1'b0);
        chk("clr_ferr", frame_err, 1'b0);
    endtask

    initial begin
        logic [7:0] dummy;
        tick(3);
        check_out("rst");
        chk("rst_miso", spi_miso, 1'b0);
        chk("rst_oe", spi_miso_oe, 1'b0);
        rst_n = 1'b1;
        tick(6);

        // single word, consumer not ready
        cs_low; xfer(8'hA5, 0); cs_high;
        check_out("t1");

        // two words in one frame with consumer ready; loopback shows previous word
        set_ready(1'b1);
        cs_low; xfer(8'h3C, 0); xfer(8'h7E, 0); cs_high;
        set_ready(1'b0);
        check_out("t2");

        // overrun
        cs_low; xfer(8'h11, 0); xfer(8'h22, 0); cs_high;
        check_out("t3");
        clear_flags;
        set_ready(1'b1); set_ready(1'b0);

        // framing error on partial word, then clean word
        cs_low; send_bits(8'hF0, 5, 0, dummy); cs_high;
        m_ferr = 1'b1;
        check_out("t4a");
        cs_low; xfer(8'h55, 0); cs_high;
        check_out("t4b");
        clear_flags;
        set_ready(1'b1); set_ready(1'b0);

        // reset mid-byte with CS held low
        cs_low; send_bits(8'hC3, 4, 0, dummy);
        rst_n = 1'b0;
        m_data = 8'h00; m_last = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        tick(2);
        check_out("t5rst");
        chk("t5rst_miso", spi_miso, 1'b0);
        chk("t5rst_oe", spi_miso_oe, 1'b0);
        rst_n = 1'b1;
        send_bits(8'hFF, 8, 0, dummy);
        tick(4);
        chk("t5_noword", rx_valid, 1'b0);
        chk("t5_oe", spi_miso_oe, 1'b0);
        cs_high;
        check_out("t5b");
        cs_low; xfer(8'h99, 0); cs_high;
        check_out("t5c");
        set_ready(1'b1); set_ready(1'b0);

        // accept in the exact completion cycle of the next word
        cs_low; xfer(8'hA1, 0); xfer(8'hB2, 1); cs_high;
        check_out("t6");
        set_ready(1'b1); set_ready(1'b0);

        // ena dropped mid-frame behaves like CS rise
        cs_low; send_bits(8'h0F, 3, 0, dummy); tick(2);
        chk("ena_oe_on", spi_miso_oe, 1'b1);
        ena = 1'b0; tick(6);
        m_ferr = 1'b1;
        chk("ena_oe_off", spi_miso_oe, 1'b0);
        ena = 1'b1; spi_cs_n = 1'b1; tick(6);
        check_out("ena");
        clear_flags;

        // randomized frames
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 3);
            set_ready(1'($urandom_range(0, 1)));
            cs_low;
            for (int k = 0; k < n; k++) xfer(8'($urandom), 0);
            cs_high;
            check_out("rnd");
            set_ready(1'b1); set_ready(1'b0);
            clear_flags;
        end

        chk("acc_count", acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk("acc_word", acc_q[i], exp_q[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
